frame_writer: RTL

//  Upstream feeder of the display frame memory. Accepts a 16-bit word stream from the processor side

---
 rtl/frame_writer.sv | 112 +++++++++++
 1 files changed

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - double-buffered frame writer: streams one frame into the back bank, swaps banks on vsync
module frame_writer #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 16,
    parameter int FRAME_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              in_ready,
    input  logic              port_busy,
    input  logic              frame_sync,
    output logic              mem_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W:0]   mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              display_bank,
    output logic              frame_done,
    output logic              sof_error
);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_SWAP} state_t;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic                bank_q, bank_d;
    logic                wr_q, wr_d;
    logic [ADDR_W:0]     addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic [ADDR_W-1:0]   wr_idx;

    assign in_ready = (state_q != WAIT_SWAP) && !port_busy;
    assign accept   = in_valid && in_ready;
    // A start-of-frame beat always lands on word 0, restarting any partial frame.
    assign wr_idx   = in_sof ? '0 : wptr_q;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        bank_d  = bank_q;
        wr_d    = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE, WRITE: begin
                // In IDLE, beats without sof are consumed and dropped.
                if (accept && (in_sof || state_q == WRITE)) begin
                    wr_d   = 1'b1;
                    addr_d = {~bank_q, wr_idx};
                    data_d = in_data;
                    err_d  = (state_q == WRITE) && in_sof;
                    if (wr_idx == LAST_WORD) begin
                        wptr_d  = '0;
                        done_d  = 1'b1;
                        state_d = WAIT_SWAP;
                    end else begin
                        wptr_d  = wr_idx + 1'b1;
                        state_d = WRITE;
                    end
                end
            end
            WAIT_SWAP: begin
                if (frame_sync) begin
                    bank_d  = ~bank_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            bank_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            bank_q  <= bank_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_enable       = wr_q;
    assign mem_write_enable = wr_q;
    assign mem_address      = addr_q;
    assign mem_data         = data_q;
    assign display_bank     = bank_q;
    assign frame_done       = done_q;
    assign sof_error        = err_q;

endmodule
